// File: rtl/rom_port_arbiter.sv
// Shares one combinational instruction ROM between fetch (IF) and load (LD).
// Arbitrates per cycle, range/alignment checks the winner, and registers a one-cycle response.
module rom_port_arbiter #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] ROM_BASE      = 32'hBFC00000,
    parameter int                       ROM_SIZE      = 4096,
    parameter int                       STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    output logic                     if_err,
    input  logic                     ld_req,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    output logic                     ld_gnt,
    output logic                     ld_rvalid,
    output logic [DATA_WIDTH-1:0]    ld_rdata,
    output logic                     ld_err,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout
);

    localparam int                     CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]       LP_LIMIT = CNT_W'(STARVE_LIMIT);
    // One extra bit so the upper bound cannot wrap for ROMs placed near the top of memory.
    localparam logic [ADDRESS_WIDTH:0] LP_LO    = {1'b0, ROM_BASE};
    localparam logic [ADDRESS_WIDTH:0] LP_HI    = LP_LO + (ADDRESS_WIDTH + 1)'(ROM_SIZE - 4);

    logic [CNT_W-1:0]         r_starve_cnt;
    logic                     r_if_rvalid;
    logic [DATA_WIDTH-1:0]    r_if_rdata;
    logic                     r_if_err;
    logic                     r_ld_rvalid;
    logic [DATA_WIDTH-1:0]    r_ld_rdata;
    logic                     r_ld_err;

    logic                     w_if_gnt;
    logic                     w_ld_gnt;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [ADDRESS_WIDTH:0]   w_sel_ext;
    logic                     w_fault;
    logic [DATA_WIDTH-1:0]    w_rdata;

    always_comb begin
        w_if_gnt   = 1'b0;
        w_ld_gnt   = 1'b0;
        w_sel_addr = '0;
        if (rst_n) begin
            if (if_req && (!ld_req || r_starve_cnt == LP_LIMIT)) begin
                w_if_gnt = 1'b1;
            end else if (ld_req) begin
                w_ld_gnt = 1'b1;
            end
        end
        if (w_if_gnt) begin
            w_sel_addr = if_addr;
        end else if (w_ld_gnt) begin
            w_sel_addr = ld_addr;
        end
        w_sel_ext = {1'b0, w_sel_addr};
        w_fault   = (w_sel_ext < LP_LO) || (w_sel_ext > LP_HI) || (w_sel_addr[1:0] != 2'b00);
        w_rdata   = w_fault ? '0 : rom_dout;
    end

    assign if_gnt   = w_if_gnt;
    assign ld_gnt   = w_ld_gnt;
    assign rom_addr = ((w_if_gnt || w_ld_gnt) && !w_fault) ? w_sel_addr : '0;

    // Counts consecutive IF losses to LD; saturates so IF wins once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (if_req && w_ld_gnt && r_starve_cnt != LP_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_ld_rvalid <= 1'b0;
            r_ld_rdata  <= '0;
            r_ld_err    <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_ld_rvalid <= w_ld_gnt;
            if (w_if_gnt) begin
                r_if_rdata <= w_rdata;
                r_if_err   <= w_fault;
            end
            if (w_ld_gnt) begin
                r_ld_rdata <= w_rdata;
                r_ld_err   <= w_fault;
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign ld_rvalid = r_ld_rvalid;
    assign ld_rdata  = r_ld_rdata;
    assign ld_err    = r_ld_err;

endmodule
